// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM states, queue entry layout and reset constants.
// No logic here; imported by instr_fetch_unit and fetch_queue.
package fetch_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          OPCODE_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Registered FIFO of fetch entries; a push is visible at the head the following cycle.
// Pushes while full are dropped, pops while empty are ignored, and flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_push_dat;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, 2-cycle accept-to-if_valid, redirect flushes in-flight work.
// Requests stop when queue+outstanding reaches QDEPTH; FETCH_PERF_CNT_EN adds pop/stall counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
  parameter int              QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                id_stall,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [XLEN-1:0]     if_pc,
  output logic [OPCODE_W-1:0] if_opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;

  fetch_entry_t    w_head;
  fetch_entry_t    w_push_dat;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_credit;
  logic            w_push;
  logic            w_pop;
  logic            w_req_fire;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_unused_redir_lsb;

  assign w_redir_pc         = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redir_lsb = ^redirect_pc[1:0];

  // Outstanding is always zero while in REQ, so credit is just free queue slots.
  assign w_credit       = (w_count < CW'(QDEPTH));
  assign imem_req_valid = (r_state == REQ) && w_credit && !redirect_valid;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // The pc has already advanced past the outstanding request.
  assign w_push_dat = '{pc: XLEN_DEF'(r_pc - XLEN'(4)), instr: imem_rsp_data};
  assign w_push     = (r_state == WAIT) && imem_rsp_valid && !redirect_valid && !w_full;
  assign w_pop      = if_valid && !id_stall;

  assign if_valid  = !w_empty;
  assign if_instr  = w_empty ? NOP_INSTR : w_head.instr;
  assign if_pc     = w_empty ? '0 : XLEN'(w_head.pc);
  assign if_opcode = if_instr[OPCODE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redir_pc;
      case (r_state)
        WAIT, DROP: r_state <= imem_rsp_valid ? REQ : DROP;
        default:    r_state <= REQ;
      endcase
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (w_req_fire) begin
            r_pc    <= r_pc + XLEN'(4);
            r_state <= WAIT;
          end
        end
        WAIT: if (imem_rsp_valid) r_state <= REQ;
        DROP: if (imem_rsp_valid) r_state <= REQ;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pop)                r_perf_fetch <= r_perf_fetch + 32'd1;
      if (if_valid && id_stall) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle tables, then random traffic against a stream-level model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'hA5C3_1E00) * 32'h0100_0193) + a;
  endfunction

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rsp;
    logic [31:0] rsp_dat;
    bit          redir;
    logic [31:0] redir_pc;
    bit          stall;
    bit          e_rv;
    logic [31:0] e_ra;
    bit          e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit rdy, input bit rsp, input logic [31:0] rsp_addr,
                     input bit redir, input logic [31:0] rpc, input bit stall,
                     input bit e_rv, input logic [31:0] e_ra, input bit e_iv, input logic [31:0] e_ipc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rsp = rsp; v.rsp_dat = mem_word(rsp_addr);
    v.redir = redir; v.redir_pc = rpc; v.stall = stall;
    v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv; v.e_ipc = e_ipc;
    vecs.push_back(v);
  endtask

  // Random-phase model state: decode stream pc, fetch stream pc, memory pipeline.
  logic [31:0] exp_pc, f_pc, acc_addr, pend_addr, prev_addr, rpc;
  bit          acc_prev, pend, prev_hold, prev_redir, redir, stall, acc;
  int          pend_dly, m_fetch, m_stall;
  logic [31:0] exp_instr;

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;

    // Seq 1: 1-cycle memory, no stall.
    add(1,0,0,0,      0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 1,32'h0,0,0);
    add(0,1,1,32'h0,  0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 1,32'h4,1,32'h0);
    add(0,1,1,32'h4,  0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 1,32'h8,1,32'h4);
    add(0,1,1,32'h8,  0,0,0, 0,0,0,0);
    add(0,0,0,0,      0,0,0, 1,32'hC,1,32'h8);
    // Seq 2: ready held low for three cycles.
    add(1,0,0,0,      0,0,0, 0,0,0,0);
    add(0,0,0,0,      0,0,0, 0,0,0,0);
    add(0,0,0,0,      0,0,0, 1,32'h0,0,0);
    add(0,0,0,0,      0,0,0, 1,32'h0,0,0);
    add(0,0,0,0,      0,0,0, 1,32'h0,0,0);
    add(0,1,0,0,      0,0,0, 1,32'h0,0,0);
    add(0,1,1,32'h0,  0,0,0, 0,0,0,0);
    add(0,0,0,0,      0,0,0, 1,32'h4,1,32'h0);
    add(0,0,0,0,      0,0,0, 1,32'h4,0,0);
    // Seq 3: decode stalled until the queue is full.
    add(1,0,0,0,      0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,1, 0,0,0,0);
    add(0,1,0,0,      0,0,1, 1,32'h0,0,0);
    add(0,1,1,32'h0,  0,0,1, 0,0,0,0);
    add(0,1,0,0,      0,0,1, 1,32'h4,1,32'h0);
    add(0,1,1,32'h4,  0,0,1, 0,0,1,32'h0);
    add(0,1,0,0,      0,0,1, 0,0,1,32'h0);
    add(0,1,0,0,      0,0,0, 0,0,1,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h8,1,32'h4);
    add(0,1,1,32'h8,  0,0,0, 0,0,0,0);
    add(0,0,0,0,      0,0,0, 1,32'hC,1,32'h8);
    // Seq 4: redirect to 0x103 while waiting for a response.
    add(1,0,0,0,      0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 1,32'h0,0,0);
    add(0,1,1,32'h0,  0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 1,32'h4,1,32'h0);
    add(0,1,0,0,      1,32'h103,0, 0,0,0,0);
    add(0,1,1,32'h4,  0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 1,32'h100,0,0);
    add(0,1,1,32'h100,0,0,0, 0,0,0,0);
    add(0,0,0,0,      0,0,0, 1,32'h104,1,32'h100);
    // Seq 5: redirect coinciding with a response and a pop.
    add(1,0,0,0,      0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 1,32'h0,0,0);
    add(0,1,1,32'h0,  0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,1, 1,32'h4,1,32'h0);
    add(0,1,1,32'h4,  1,32'h200,0, 0,0,1,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h200,0,0);
    add(0,1,1,32'h200,0,0,0, 0,0,0,0);
    add(0,0,0,0,      0,0,0, 1,32'h204,1,32'h200);
    // Seq 6: reset while a request is outstanding, then a late response.
    add(1,0,0,0,      0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 0,0,0,0);
    add(0,1,0,0,      0,0,0, 1,32'h0,0,0);
    add(1,0,0,0,      0,0,0, 0,0,0,0);
    add(0,0,1,32'h40, 0,0,0, 0,0,0,0);
    add(0,0,1,32'h40, 0,0,0, 1,32'h0,0,0);
    add(0,0,0,0,      0,0,0, 1,32'h0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n          = !vecs[i].rst;
      imem_req_ready = vecs[i].rdy;
      imem_rsp_valid = vecs[i].rsp;
      imem_rsp_data  = vecs[i].rsp_dat;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].redir_pc;
      id_stall       = vecs[i].stall;
      #1;
      exp_instr = vecs[i].e_iv ? mem_word(vecs[i].e_ipc) : NOP_INSTR;
      chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_ra);
      chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d_if_pc", i), if_pc, vecs[i].e_iv ? vecs[i].e_ipc : 32'h0);
      chk($sformatf("v%0d_if_instr", i), if_instr, exp_instr);
      chk($sformatf("v%0d_if_opcode", i), 32'(if_opcode), 32'(exp_instr[6:0]));
    end

    // Random traffic against a stream-level model.
    @(negedge clk);
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; id_stall = 1'b0;
    exp_pc = '0; f_pc = '0; acc_prev = 0; pend = 0; pend_dly = 0; prev_hold = 0; prev_redir = 0;
    prev_addr = '0; acc_addr = '0; pend_addr = '0; m_fetch = 0; m_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (acc_prev) begin
        pend      = 1;
        pend_addr = acc_addr;
        pend_dly  = int'($urandom_range(0, 2));
        acc_prev  = 0;
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (pend) begin
        if (pend_dly == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend = 0;
        end else begin
          pend_dly--;
        end
      end
      redir = ($urandom_range(0, 19) == 0);
      rpc   = $urandom & 32'h0000_FFFF;
      stall = ($urandom_range(0, 2) == 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = redir;
      redirect_pc    = rpc;
      id_stall       = stall;
      #1;
      if (redir) chk("rand_no_req_on_redirect", 32'(imem_req_valid), 32'd0);
      if (prev_hold && !redir) begin
        chk("rand_req_valid_held", 32'(imem_req_valid), 32'd1);
        chk("rand_req_addr_stable", imem_req_addr, prev_addr);
      end
      if (prev_redir) chk("rand_flush_after_redirect", 32'(if_valid), 32'd0);
      if (imem_req_valid) chk("rand_req_addr", imem_req_addr, f_pc);
      if (if_valid) begin
        chk("rand_if_pc", if_pc, exp_pc);
        chk("rand_if_instr", if_instr, mem_word(exp_pc));
        chk("rand_if_opcode", 32'(if_opcode), 32'(mem_word(exp_pc) & 32'h7F));
        if (!stall) begin
          exp_pc = exp_pc + 32'd4;
          m_fetch++;
        end else begin
          m_stall++;
        end
      end else begin
        chk("rand_idle_pc", if_pc, 32'h0);
        chk("rand_idle_instr", if_instr, NOP_INSTR);
      end
      acc = imem_req_valid && imem_req_ready;
      if (acc) begin
        acc_prev = 1;
        acc_addr = imem_req_addr;
        f_pc     = f_pc + 32'd4;
      end
      if (redir) begin
        exp_pc = rpc & 32'hFFFF_FFFC;
        f_pc   = rpc & 32'hFFFF_FFFC;
      end
      prev_hold  = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
      prev_redir = redir;
    end
    chk("rand_progress", 32'(m_fetch > 100), 32'd1);

`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    redirect_valid = 1'b0; id_stall = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    if (if_valid) m_fetch++;
    @(negedge clk);
    id_stall = 1'b1;
    #1;
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetch));
    chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stall));
    rst_n = 1'b0;
    #1;
    chk("perf_fetch_reset", perf_fetch_cnt, 32'h0);
    chk("perf_stall_reset", perf_stall_cnt, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
